// File: rtl/writeback_mp.sv
// ---------------------------------------------------------------------------
// writeback_mp
//
// Multi-lane writeback stage. Each lane carries its decode-time destination
// register down a short alignment line so it meets the matching execution
// result, then registers a register-file write. Writes to x0 are dropped.
// When several lanes target the same register in one cycle, only the
// highest-index lane writes. A retire counter tallies every valid uop,
// including dropped ones.
//
// Ports
//   clk           : single clock, rising edge
//   reset         : asynchronous, active-low reset
//   mem_stall     : freezes the alignment line and suppresses writes
//   rd_decode     : per-lane destination register from decode (packed lanes)
//   exe_result    : per-lane execution result (packed lanes)
//   uop_valid_in  : per-lane valid for exe_result
//   wb_addr       : per-lane register-file write address (registered)
//   wb_data       : per-lane register-file write data (registered)
//   wb_en         : per-lane register-file write enable (registered pulse)
//   retire_cnt    : running count of retired uops, wraps silently
// ---------------------------------------------------------------------------
module writeback_mp #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int LANES          = 2,
   parameter int RD_DELAY       = 2,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            mem_stall,
   input  logic [LANES*REG_ADDR_WIDTH-1:0] rd_decode,
   input  logic [LANES*DATA_WIDTH-1:0]     exe_result,
   input  logic [LANES-1:0]                uop_valid_in,
   output logic [LANES*REG_ADDR_WIDTH-1:0] wb_addr,
   output logic [LANES*DATA_WIDTH-1:0]     wb_data,
   output logic [LANES-1:0]                wb_en,
   output logic [CNT_WIDTH-1:0]            retire_cnt
);

   // Destination alignment line: index 0 is the newest sample, index
   // RD_DELAY-1 is the destination that pairs with the current result.
   logic [REG_ADDR_WIDTH-1:0] rd_line [LANES][RD_DELAY];
   logic [REG_ADDR_WIDTH-1:0] rd_al   [LANES];
   logic [LANES-1:0]          en_nxt;
   logic [CNT_WIDTH-1:0]      valid_cnt;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         rd_al[i] = rd_line[i][RD_DELAY-1];
      end
   end

   // Write-enable selection: drop x0 writes, and let a higher lane win over
   // any lower lane aiming at the same register in the same cycle.
   // NOTE: every variable driven here gets a default before any condition,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      en_nxt = '0;
      for (int i = 0; i < LANES; i++) begin
         en_nxt[i] = uop_valid_in[i] && (rd_al[i] != '0);
      end
      for (int i = 0; i < LANES; i++) begin
         for (int j = 0; j < LANES; j++) begin
            if ((j > i) && uop_valid_in[j] && (rd_al[j] == rd_al[i])) begin
               en_nxt[i] = 1'b0;
            end
         end
      end
   end

   // Popcount of valid lanes; suppressed uops still retire.
   always_comb begin
      valid_cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         valid_cnt = valid_cnt + CNT_WIDTH'(uop_valid_in[i]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, which is what makes the shift line shift.
   // NOTE: the alignment line is a handful of flops, not a RAM, so it is
   // cleared on reset; this is what forces post-reset writes to x0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < RD_DELAY; k++) begin
               rd_line[i][k] <= '0;
            end
         end
         wb_addr    <= '0;
         wb_data    <= '0;
         wb_en      <= '0;
         retire_cnt <= '0;
      end else if (mem_stall) begin
         // Frozen: line and write payload hold, no write is issued.
         wb_en <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            rd_line[i][0] <= rd_decode[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            for (int k = 1; k < RD_DELAY; k++) begin
               rd_line[i][k] <= rd_line[i][k-1];
            end
            if (uop_valid_in[i]) begin
               wb_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] <= rd_al[i];
               wb_data[i*DATA_WIDTH +: DATA_WIDTH]         <= exe_result[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         wb_en      <= en_nxt;
         retire_cnt <= retire_cnt + valid_cnt;
      end
   end

endmodule

// File: tb/tb_writeback_mp.sv
// ---------------------------------------------------------------------------
// tb_writeback_mp
//
// Directed bench for writeback_mp (LANES=2, RD_DELAY=2, 32-bit data/count).
// A second instance with a 2-bit retire counter shares the stimulus so the
// counter wrap can be observed. A reference model built on a history queue
// of sampled destinations predicts every output; a compare process checks
// it each cycle, and literal checks pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_writeback_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int LN = 2;
   localparam int RD = 2;
   localparam int CW = 32;

   logic              clk;
   logic              reset;
   logic              mem_stall;
   logic [LN*AW-1:0]  rd_decode;
   logic [LN*DW-1:0]  exe_result;
   logic [LN-1:0]     uop_valid_in;
   logic [LN*AW-1:0]  wb_addr;
   logic [LN*DW-1:0]  wb_data;
   logic [LN-1:0]     wb_en;
   logic [CW-1:0]     retire_cnt;

   logic [LN*AW-1:0]  s_wb_addr;
   logic [LN*DW-1:0]  s_wb_data;
   logic [LN-1:0]     s_wb_en;
   logic [1:0]        s_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   writeback_mp #(
      .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .LANES(LN), .RD_DELAY(RD), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset), .mem_stall(mem_stall), .rd_decode(rd_decode),
      .exe_result(exe_result), .uop_valid_in(uop_valid_in), .wb_addr(wb_addr),
      .wb_data(wb_data), .wb_en(wb_en), .retire_cnt(retire_cnt)
   );

   writeback_mp #(
      .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .LANES(LN), .RD_DELAY(RD), .CNT_WIDTH(2)
   ) dut_small (
      .clk(clk), .reset(reset), .mem_stall(mem_stall), .rd_decode(rd_decode),
      .exe_result(exe_result), .uop_valid_in(uop_valid_in), .wb_addr(s_wb_addr),
      .wb_data(s_wb_data), .wb_en(s_wb_en), .retire_cnt(s_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [AW-1:0] hq0[$];
   logic [AW-1:0] hq1[$];
   logic [AW-1:0] m_addr0 = '0, m_addr1 = '0;
   logic [DW-1:0] m_data0 = '0, m_data1 = '0;
   logic [1:0]    m_en    = '0;
   logic [CW-1:0] m_cnt   = '0;

   always @(posedge clk or negedge reset) begin
      logic [AW-1:0] al0, al1;
      logic          v0, v1;
      if (!reset) begin
         hq0.delete();
         hq1.delete();
         m_addr0 = '0; m_addr1 = '0;
         m_data0 = '0; m_data1 = '0;
         m_en    = '0;
         m_cnt   = '0;
      end else if (mem_stall) begin
         m_en = '0;
      end else begin
         // Destination sampled RD unstalled edges ago, or 0 if none since reset.
         al0 = (hq0.size() >= RD) ? hq0[RD-1] : '0;
         al1 = (hq1.size() >= RD) ? hq1[RD-1] : '0;
         hq0.push_front(rd_decode[AW-1:0]);
         hq1.push_front(rd_decode[2*AW-1:AW]);
         if (hq0.size() > RD) void'(hq0.pop_back());
         if (hq1.size() > RD) void'(hq1.pop_back());
         v0 = uop_valid_in[0];
         v1 = uop_valid_in[1];
         if (v0) begin m_addr0 = al0; m_data0 = exe_result[DW-1:0]; end
         if (v1) begin m_addr1 = al1; m_data1 = exe_result[2*DW-1:DW]; end
         m_en[1] = v1 && (al1 != 0);
         m_en[0] = v0 && (al0 != 0) && !(v1 && (al1 == al0));
         m_cnt   = m_cnt + CW'(v0) + CW'(v1);
      end
   end

   always @(negedge clk) begin
      check("wb_addr",     64'(wb_addr),    64'({m_addr1, m_addr0}));
      check("wb_data",     64'(wb_data),    {m_data1, m_data0});
      check("wb_en",       64'(wb_en),      64'(m_en));
      check("retire_cnt",  64'(retire_cnt), 64'(m_cnt));
      check("small_cnt",   64'(s_cnt),      64'(m_cnt[1:0]));
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic st, input logic [1:0] v, input logic [AW-1:0] r0,
                        input logic [AW-1:0] r1, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
      @(negedge clk);
      #1;
      mem_stall    = st;
      uop_valid_in = v;
      rd_decode    = {r1, r0};
      exe_result   = {e1, e0};
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset        = 1'b0;
      mem_stall    = 1'b0;
      uop_valid_in = '0;
      rd_decode    = '0;
      exe_result   = '0;

      #2;
      check("reset_en",   64'(wb_en),      64'h0);
      check("reset_addr", 64'(wb_addr),    64'h0);
      check("reset_data", 64'(wb_data),    64'h0);
      check("reset_cnt",  64'(retire_cnt), 64'h0);
      repeat (2) @(posedge clk);
      @(negedge clk); #1; reset = 1'b1;

      // Alignment: rd=5 at edge 1, result at edge 3.
      drive(0, 2'b00, 5, 0, 0, 0);          after_edge();
      drive(0, 2'b00, 0, 0, 0, 0);          after_edge();
      drive(0, 2'b01, 0, 0, 32'hA5A5A5A5, 0); after_edge();
      check("align_addr0", 64'(wb_addr[AW-1:0]), 64'd5);
      check("align_data0", 64'(wb_data[DW-1:0]), 64'hA5A5A5A5);
      check("align_en",    64'(wb_en),           64'b01);
      drive(0, 2'b00, 0, 0, 0, 0);          after_edge();
      check("align_pulse", 64'(wb_en),      64'b00);
      check("align_cnt",   64'(retire_cnt), 64'd1);

      // Stall on edge 2: write moves to edge 4.
      drive(0, 2'b00, 5, 0, 0, 0);          after_edge();
      drive(1, 2'b01, 9, 0, 32'hDEAD, 0);   after_edge();
      check("stall_en",    64'(wb_en),           64'b00);
      check("stall_hold",  64'(wb_data[DW-1:0]), 64'hA5A5A5A5);
      drive(0, 2'b00, 0, 0, 0, 0);          after_edge();
      check("stall_e3_en", 64'(wb_en),      64'b00);
      drive(0, 2'b01, 0, 0, 32'hC3C3C3C3, 0); after_edge();
      check("stall_addr0", 64'(wb_addr[AW-1:0]), 64'd5);
      check("stall_data0", 64'(wb_data[DW-1:0]), 64'hC3C3C3C3);
      check("stall_en4",   64'(wb_en),           64'b01);
      check("stall_cnt",   64'(retire_cnt),      64'd2);

      // x0 suppression on lane 1.
      drive(0, 2'b10, 0, 0, 0, 32'h1234);   after_edge();
      check("x0_en",    64'(wb_en),                64'b00);
      check("x0_data1", 64'(wb_data[2*DW-1:DW]),   64'h1234);
      check("x0_cnt",   64'(retire_cnt),           64'd3);
      check("x0_small", 64'(s_cnt),                64'd3);

      // Conflict: both lanes target register 7; small counter wraps 3 -> 1.
      drive(0, 2'b00, 7, 7, 0, 0);          after_edge();
      drive(0, 2'b00, 0, 0, 0, 0);          after_edge();
      drive(0, 2'b11, 0, 0, 32'h11, 32'h22); after_edge();
      check("conf_en",    64'(wb_en),              64'b10);
      check("conf_addr1", 64'(wb_addr[2*AW-1:AW]), 64'd7);
      check("conf_data1", 64'(wb_data[2*DW-1:DW]), 64'h22);
      check("conf_data0", 64'(wb_data[DW-1:0]),    64'h11);
      check("conf_cnt",   64'(retire_cnt),         64'd5);
      check("wrap_small", 64'(s_cnt),              64'd1);

      // Two distinct destinations, then async reset while wb_en=11.
      drive(0, 2'b00, 3, 4, 0, 0);          after_edge();
      drive(0, 2'b00, 6, 6, 0, 0);          after_edge();
      drive(0, 2'b11, 6, 6, 32'hAA, 32'hBB); after_edge();
      check("dual_en",   64'(wb_en),      64'b11);
      check("dual_addr", 64'(wb_addr),    64'({5'd4, 5'd3}));
      check("dual_cnt",  64'(retire_cnt), 64'd7);
      #2 reset = 1'b0;
      #1;
      check("arst_en",   64'(wb_en),      64'h0);
      check("arst_addr", 64'(wb_addr),    64'h0);
      check("arst_data", 64'(wb_data),    64'h0);
      check("arst_cnt",  64'(retire_cnt), 64'h0);
      drive(0, 2'b11, 2, 3, 1, 2);          after_edge();
      check("arst_hold", 64'(wb_en),      64'h0);
      drive(0, 2'b00, 0, 0, 0, 0);
      reset = 1'b1;
      after_edge();

      // After release: first two accepted uops per lane land on x0.
      drive(0, 2'b11, 2, 3, 1, 2);          after_edge();
      check("post1_en",  64'(wb_en),      64'b00);
      check("post1_cnt", 64'(retire_cnt), 64'd2);
      drive(0, 2'b11, 0, 0, 3, 4);          after_edge();
      check("post2_en",  64'(wb_en),      64'b00);
      check("post2_cnt", 64'(retire_cnt), 64'd4);
      drive(0, 2'b11, 0, 0, 5, 6);          after_edge();
      check("post3_en",   64'(wb_en),     64'b11);
      check("post3_addr", 64'(wb_addr),   64'({5'd3, 5'd2}));
      check("post3_cnt",  64'(retire_cnt), 64'd6);

      // Mixed tail: stalls, valids and a tiny destination set to provoke
      // x0 writes and conflicts; the model checks every cycle.
      for (int n = 0; n < 80; n++) begin
         drive(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
               5'($urandom_range(0, 2)), 5'($urandom_range(0, 2)),
               $urandom, $urandom);
      end
      drive(0, 2'b00, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
